bcd_time_accum: RTL and testbench
=================================

# bcd_time_accum

Downstream stage of the divide-by-10 tick counter: consumes its one-cycle carry (`cout`) as a count-enable and accumulates elapsed time as a four-digit BCD MM:SS value (00:00 to 59:59). Provides start/stop/clear control, a sticky overflow flag and an optional lap-capture register. Feeds the display/scan stage with registered BCD digits.

## Interface
- `SATURATE`, default 0: 0 = wrap 59:59 to 00:00 and keep running; 1 = hold at 59:59 and stop.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rstn` input 1: asynchronous, active-low reset.
- `tick` input 1: count enable, the upstream carry; one-cycle pulse, any spacing ≥1 cycle.
- `start` input 1: level-sampled start request.
- `stop` input 1: level-sampled stop request.
- `clr` input 1: synchronous clear.
- `lap` input 1: lap-capture request (used only with `LAP_EN`).
- `sec_lo` output 4: seconds units, BCD 0–9.
- `sec_hi` output 4: seconds tens, BCD 0–5.
- `min_lo` output 4: minutes units, BCD 0–9.
- `min_hi` output 4: minutes tens, BCD 0–5.
- `running` output 1: high when state is RUN.
- `ovf` output 1: sticky; set on the 59:59 boundary tick.
- `lap_time` output 16: captured {min_hi,min_lo,sec_hi,sec_lo}.
- `lap_valid` output 1: high from the first capture until `clr`.

## Operation
- Reset (`rstn`=0, asynchronous): state IDLE; all digits 0; `running`=0, `ovf`=0, `lap_time`=16'h0000, `lap_valid`=0.
- States:
  - IDLE: value 00:00, stopped.
  - RUN: counting.
  - HOLD: stopped, value retained.
- Control priority, evaluated each cycle: `clr` > `stop` > `start`.
- `clr` from any state: digits ← 0, `ovf` ← 0, `lap_valid` ← 0, `lap_time` ← 0, state ← IDLE. A `tick` in the same cycle is discarded.
- `stop` in RUN: state ← HOLD. A tick in the same cycle is still counted, because the stop takes effect after the edge.
- `start` in IDLE or HOLD: state ← RUN. A tick in the same cycle is not counted.
- Inputs with no effect:
  - `start` while in RUN.
  - `stop` while in IDLE or HOLD.
  - `tick` outside RUN.
- Counting, on `tick` in RUN. The carry chain is evaluated combinationally from the current digits; one tick advances the value by exactly one second.
  - `sec_lo`: 9 → 0 with carry, else +1.
  - `sec_hi`: on carry, 5 → 0 with carry, else +1.
  - `min_lo`: on carry, 9 → 0 with carry, else +1.
  - `min_hi`: on carry, 5 → boundary, else +1.
- Boundary (59:59 plus tick):
  - `ovf` ← 1 in both modes.
  - `SATURATE`=0: value → 00:00, stay in RUN.
  - `SATURATE`=1: value stays 59:59, state ← HOLD.
- Digits never hold non-BCD values. Legal ranges: lo digits 0–9, hi digits 0–5.
- Reset mid-count: immediate return to the reset values, with no dependence on `clk`.

## Timing
- Outputs are registered. A tick sampled at edge N is visible in the digits after edge N; latency is 1 cycle.
- `running` rises one cycle after `start` is sampled and falls one cycle after `stop` is sampled.
- `ovf` asserts in the same cycle the digits show the boundary result.
- Back-to-back ticks on consecutive cycles are each counted. No throughput limit.
- `lap` capture:
  - Takes the pre-increment value when `tick` coincides.
  - Visible one cycle after `lap` is sampled.

## Configuration
- Macro: `BCD_TIME_LAP_EN`.
- Defined:
  - `lap` sampled high in RUN: `lap_time` ← current {min_hi,min_lo,sec_hi,sec_lo} and `lap_valid` ← 1.
  - `lap` is ignored in IDLE and HOLD.
  - A later lap overwrites the earlier one.
- Undefined:
  - `lap` is ignored.
  - `lap_time` is tied to 16'h0000 and `lap_valid` to 0.
  - No lap registers are synthesized.
  - The port list is unchanged.

## Test plan
- **Reset and start:** reset, start, then 10 ticks one cycle apart → digits read 00:10 (`sec_hi`=1, `sec_lo`=0); `running`=1; `ovf`=0.
- **Minute carry:** start from 00:00 and apply 3599 ticks → 59:59; one more tick:
  - `SATURATE`=0: 00:00, `ovf`=1, `running`=1.
  - `SATURATE`=1: 59:59, `ovf`=1, `running`=0.
- **Simultaneous controls:**
  - At 00:05, `stop` and `tick` together → 00:06 and HOLD.
  - Then `start` and `tick` together → stays 00:06 and RUN.
  - Then `clr`, `stop` and `tick` together → 00:00 and IDLE.
- **Ticks outside RUN:** 20 ticks in IDLE and in HOLD → value unchanged; `running`=0 throughout.
- **Asynchronous reset mid-count:** assert `rstn`=0 at 12:34, between clock edges → all digits 0 and `ovf`=0 before the next edge; ticks ignored until `start`.
- **Lap capture (with `BCD_TIME_LAP_EN`):** at 01:29, `lap` and `tick` together → `lap_time`=16'h0129, `lap_valid`=1, digits 01:30. Without the macro, `lap_time` stays 16'h0000.

Source files
------------

// File: rtl/bcd_time_accum.sv
// bcd_time_accum: accumulates elapsed time as four BCD digits (MM:SS,
// 00:00..59:59), advanced by the one-cycle carry of the upstream tick counter.
// It has start/stop/clear control, a sticky overflow flag and an optional
// lap-capture register.
//
// Parameter
//   SATURATE   0: wrap 59:59 -> 00:00 and keep running
//              1: hold at 59:59 and stop
// Configuration macro
//   BCD_TIME_LAP_EN   when defined, builds the lap-capture registers;
//                     otherwise lap_time/lap_valid are tied to zero
// Ports
//   clk, rstn                  clock, asynchronous active-low reset
//   tick                       count enable (one-cycle upstream carry)
//   start, stop, clr           control (priority clr > stop > start)
//   lap                        lap-capture request
//   sec_lo, sec_hi             seconds digits (registered BCD)
//   min_lo, min_hi             minutes digits (registered BCD)
//   running                    high while counting
//   ovf                        sticky, set on the 59:59 boundary tick
//   lap_time, lap_valid        captured {min_hi,min_lo,sec_hi,sec_lo}, valid
module bcd_time_accum #(
  parameter bit SATURATE = 1'b0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        tick,
  input  logic        start,
  input  logic        stop,
  input  logic        clr,
  input  logic        lap,
  output logic [3:0]  sec_lo,
  output logic [3:0]  sec_hi,
  output logic [3:0]  min_lo,
  output logic [3:0]  min_hi,
  output logic        running,
  output logic        ovf,
  output logic [15:0] lap_time,
  output logic        lap_valid
);

  localparam int unsigned DIGIT_W = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [DIGIT_W-1:0] sec_lo_q, sec_lo_d, sec_hi_q, sec_hi_d;
  logic [DIGIT_W-1:0] min_lo_q, min_lo_d, min_hi_q, min_hi_d;
  logic               running_q, running_d;
  logic               ovf_q, ovf_d;

  // Carry chain from the current digits; at_max_c marks 59:59.
  logic               c_sl_c, c_sh_c, c_ml_c, at_max_c;
  logic [DIGIT_W-1:0] sec_lo_inc_c, sec_hi_inc_c, min_lo_inc_c, min_hi_inc_c;

  always_comb begin
    c_sl_c   = (sec_lo_q == DIGIT_W'(9));
    c_sh_c   = c_sl_c & (sec_hi_q == DIGIT_W'(5));
    c_ml_c   = c_sh_c & (min_lo_q == DIGIT_W'(9));
    at_max_c = c_ml_c & (min_hi_q == DIGIT_W'(5));

    sec_lo_inc_c = c_sl_c ? '0 : sec_lo_q + DIGIT_W'(1);
    sec_hi_inc_c = sec_hi_q;
    min_lo_inc_c = min_lo_q;
    min_hi_inc_c = min_hi_q;
    if (c_sl_c) sec_hi_inc_c = (sec_hi_q == DIGIT_W'(5)) ? '0 : sec_hi_q + DIGIT_W'(1);
    if (c_sh_c) min_lo_inc_c = (min_lo_q == DIGIT_W'(9)) ? '0 : min_lo_q + DIGIT_W'(1);
    if (c_ml_c) min_hi_inc_c = (min_hi_q == DIGIT_W'(5)) ? '0 : min_hi_q + DIGIT_W'(1);
  end

`ifdef BCD_TIME_LAP_EN
  logic [15:0] lap_time_q, lap_time_d;
  logic        lap_valid_q, lap_valid_d;
`else
  logic unused_lap_c;
  assign unused_lap_c = lap;
`endif

  // Next-state: control decode, counting and optional lap capture.
  always_comb begin
    state_d  = state_q;
    sec_lo_d = sec_lo_q;
    sec_hi_d = sec_hi_q;
    min_lo_d = min_lo_q;
    min_hi_d = min_hi_q;
    ovf_d    = ovf_q;
`ifdef BCD_TIME_LAP_EN
    lap_time_d  = lap_time_q;
    lap_valid_d = lap_valid_q;
`endif

    if (clr) begin
      state_d  = ST_IDLE;
      sec_lo_d = '0;
      sec_hi_d = '0;
      min_lo_d = '0;
      min_hi_d = '0;
      ovf_d    = 1'b0;
`ifdef BCD_TIME_LAP_EN
      lap_time_d  = '0;
      lap_valid_d = 1'b0;
`endif
    end else begin
      case (state_q)
        ST_RUN: begin
`ifdef BCD_TIME_LAP_EN
          // Capture the pre-increment value.
          if (lap) begin
            lap_time_d  = {min_hi_q, min_lo_q, sec_hi_q, sec_lo_q};
            lap_valid_d = 1'b1;
          end
`endif
          // Stop lands after this edge, so a coincident tick still counts.
          if (stop) state_d = ST_HOLD;
          if (tick) begin
            if (at_max_c) ovf_d = 1'b1;
            if (at_max_c && SATURATE) begin
              state_d = ST_HOLD;
            end else begin
              // At 59:59 the increment values are all zero (wrap).
              sec_lo_d = sec_lo_inc_c;
              sec_hi_d = sec_hi_inc_c;
              min_lo_d = min_lo_inc_c;
              min_hi_d = min_hi_inc_c;
            end
          end
        end
        ST_IDLE, ST_HOLD: begin
          if (start) state_d = ST_RUN;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    running_d = (state_d == ST_RUN);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      sec_lo_q  <= '0;
      sec_hi_q  <= '0;
      min_lo_q  <= '0;
      min_hi_q  <= '0;
      running_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sec_lo_q  <= sec_lo_d;
      sec_hi_q  <= sec_hi_d;
      min_lo_q  <= min_lo_d;
      min_hi_q  <= min_hi_d;
      running_q <= running_d;
      ovf_q     <= ovf_d;
    end
  end

`ifdef BCD_TIME_LAP_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lap_time_q  <= '0;
      lap_valid_q <= 1'b0;
    end else begin
      lap_time_q  <= lap_time_d;
      lap_valid_q <= lap_valid_d;
    end
  end

  assign lap_time  = lap_time_q;
  assign lap_valid = lap_valid_q;
`else
  assign lap_time  = 16'h0000;
  assign lap_valid = 1'b0;
`endif

  assign sec_lo  = sec_lo_q;
  assign sec_hi  = sec_hi_q;
  assign min_lo  = min_lo_q;
  assign min_hi  = min_hi_q;
  assign running = running_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_bcd_time_accum.sv
// Bench for bcd_time_accum: a wrapping (u0) and a saturating (u1) instance
// share stimulus and are compared every cycle against a seconds-count model.
module tb_bcd_time_accum;

`ifdef BCD_TIME_LAP_EN
  localparam bit LAP = 1'b1;
`else
  localparam bit LAP = 1'b0;
`endif

  logic clk = 1'b0, rstn = 1'b1;
  logic tick = 1'b0, start = 1'b0, stop = 1'b0, clr = 1'b0, lap = 1'b0;
  logic [3:0]  sl[2], sh[2], ml[2], mh[2];
  logic        run[2], ov[2], lv[2];
  logic [15:0] lt[2];

  bcd_time_accum #(.SATURATE(1'b0)) u0 (
    .clk(clk), .rstn(rstn), .tick(tick), .start(start), .stop(stop), .clr(clr), .lap(lap),
    .sec_lo(sl[0]), .sec_hi(sh[0]), .min_lo(ml[0]), .min_hi(mh[0]),
    .running(run[0]), .ovf(ov[0]), .lap_time(lt[0]), .lap_valid(lv[0]));

  bcd_time_accum #(.SATURATE(1'b1)) u1 (
    .clk(clk), .rstn(rstn), .tick(tick), .start(start), .stop(stop), .clr(clr), .lap(lap),
    .sec_lo(sl[1]), .sec_hi(sh[1]), .min_lo(ml[1]), .min_hi(mh[1]),
    .running(run[1]), .ovf(ov[1]), .lap_time(lt[1]), .lap_valid(lv[1]));

  always #5 clk = ~clk;

  int nchk = 0, npass = 0;
  bit cmp_en = 1'b0;

  // Model: elapsed seconds as an integer, state 0=idle 1=run 2=hold.
  int          m_secs[2];
  int          m_st[2];
  bit          m_ovf[2];
  logic [15:0] m_lapt[2];
  bit          m_lapv[2];

  function automatic logic [15:0] to_bcd(input int s);
    int mm, ss;
    mm = s / 60;
    ss = s % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 2; i++) begin
        m_secs[i] = 0; m_st[i] = 0; m_ovf[i] = 0; m_lapt[i] = '0; m_lapv[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (clr) begin
          m_secs[i] = 0; m_st[i] = 0; m_ovf[i] = 0; m_lapt[i] = '0; m_lapv[i] = 0;
        end else if (m_st[i] == 1) begin
          if (lap && LAP) begin
            m_lapt[i] = to_bcd(m_secs[i]);
            m_lapv[i] = 1;
          end
          if (stop) m_st[i] = 2;
          if (tick) begin
            if (m_secs[i] == 3599) begin
              m_ovf[i] = 1;
              if (i == 1) m_st[i] = 2;
              else        m_secs[i] = 0;
            end else begin
              m_secs[i] = m_secs[i] + 1;
            end
          end
        end else if (start) begin
          m_st[i] = 1;
        end
      end
    end
  end

  function automatic logic [34:0] dut_vec(input int i);
    return {mh[i], ml[i], sh[i], sl[i], run[i], ov[i], lv[i], lt[i]};
  endfunction

  function automatic logic [34:0] exp_vec(input int i);
    return {to_bcd(m_secs[i]), m_st[i] == 1, m_ovf[i], m_lapv[i], m_lapt[i]};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  // Literal check of {digits, running, ovf} on one instance.
  task automatic lit(input string nm, input int i, input logic [15:0] d,
                     input logic r, input logic o);
    chk($sformatf("%s_u%0d", nm, i), 64'({mh[i], ml[i], sh[i], sl[i], run[i], ov[i]}),
        64'({d, r, o}));
  endtask

  always @(negedge clk) begin
    if (cmp_en)
      for (int i = 0; i < 2; i++)
        chk($sformatf("cycle_u%0d", i), 64'(dut_vec(i)), 64'(exp_vec(i)));
  end

  task automatic step(input bit t, input bit s, input bit p, input bit c, input bit l);
    @(negedge clk);
    tick = t; start = s; stop = p; clr = c; lap = l;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0);
  endtask

  initial begin
    int r;
    #1 rstn = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      lit("reset", i, 16'h0000, 1'b0, 1'b0);
      chk($sformatf("reset_lap_u%0d", i), 64'({lv[i], lt[i]}), 64'(17'h0));
    end
    @(negedge clk);
    rstn = 1'b1;
    cmp_en = 1'b1;

    // Start then ten ticks.
    step(0, 1, 0, 0, 0);
    repeat (10) step(1, 0, 0, 0, 0);
    idle();
    for (int i = 0; i < 2; i++) lit("ten_ticks", i, 16'h0010, 1'b1, 1'b0);

    // Up to 59:59 then the boundary tick.
    repeat (3589) step(1, 0, 0, 0, 0);
    idle();
    for (int i = 0; i < 2; i++) lit("at_5959", i, 16'h5959, 1'b1, 1'b0);
    step(1, 0, 0, 0, 0);
    idle();
    lit("boundary_wrap", 0, 16'h0000, 1'b1, 1'b1);
    lit("boundary_sat", 1, 16'h5959, 1'b0, 1'b1);

    // Simultaneous controls.
    step(0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 0);
    repeat (5) step(1, 0, 0, 0, 0);
    idle();
    for (int i = 0; i < 2; i++) lit("at_0005", i, 16'h0005, 1'b1, 1'b0);
    step(1, 0, 1, 0, 0);
    idle();
    for (int i = 0; i < 2; i++) lit("stop_tick", i, 16'h0006, 1'b0, 1'b0);
    step(1, 1, 0, 0, 0);
    idle();
    for (int i = 0; i < 2; i++) lit("start_tick", i, 16'h0006, 1'b1, 1'b0);
    step(1, 0, 1, 1, 0);
    idle();
    for (int i = 0; i < 2; i++) lit("clr_stop_tick", i, 16'h0000, 1'b0, 1'b0);

    // Ticks in IDLE, then in HOLD.
    repeat (20) step(1, 0, 0, 0, 0);
    idle();
    for (int i = 0; i < 2; i++) lit("idle_ticks", i, 16'h0000, 1'b0, 1'b0);
    step(0, 1, 0, 0, 0);
    repeat (3) step(1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    repeat (20) step(1, 0, 0, 0, 0);
    idle();
    for (int i = 0; i < 2; i++) lit("hold_ticks", i, 16'h0003, 1'b0, 1'b0);

    // Asynchronous reset at 12:34, between edges.
    step(0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 0);
    repeat (754) step(1, 0, 0, 0, 0);
    idle();
    for (int i = 0; i < 2; i++) lit("at_1234", i, 16'h1234, 1'b1, 1'b0);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) lit("async_reset", i, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (5) step(1, 0, 0, 0, 0);
    idle();
    for (int i = 0; i < 2; i++) lit("post_reset_ticks", i, 16'h0000, 1'b0, 1'b0);

    // Lap capture at 01:29 with a coincident tick.
    step(0, 1, 0, 0, 0);
    repeat (89) step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1);
    idle();
    for (int i = 0; i < 2; i++) begin
      lit("lap_digits", i, 16'h0130, 1'b1, 1'b0);
      chk($sformatf("lap_time_u%0d", i), 64'({lv[i], lt[i]}),
          LAP ? 64'(17'h1_0129) : 64'(17'h0));
    end

    // Randomized control/tick mix, with one asynchronous reset pulse.
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      step(1'($urandom_range(0, 1)), r < 6, r >= 6 && r < 9, r == 99,
           $urandom_range(0, 9) == 0);
      if (n == 1500) begin
        #2 rstn = 1'b0;
        #1 rstn = 1'b1;
      end
    end
    idle();
    idle();
    cmp_en = 1'b0;

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
